// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer: turns single-cycle load/store decode into a req/ready
// handshake, stalls the PC while outstanding, and aligns/extends load data for writeback.
module dmem_access_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        mem_fault_o
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StFault} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            mem_fault_q, mem_fault_d;
    logic [1:0]      size_q, size_d;
    logic            zext_q, zext_d;
    logic [1:0]      off_q, off_d;

    logic            access;
    logic            misaligned;
    logic [3:0]      be_dec;
    logic [31:0]     wdata_rep;
    logic [31:0]     rdata_shift;
    logic [31:0]     rdata_aligned;

    assign access = memread_i | memwrite_i;

    // Decode-side helpers, driven straight from the ALU/decode inputs.
    always_comb begin
        misaligned = 1'b0;
        be_dec     = 4'b0000;
        wdata_rep  = wdata_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr_i[1:0];
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_dec     = 4'b0011 << addr_i[1:0];
                wdata_rep  = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = (addr_i[1:0] != 2'b00);
                be_dec     = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Load lane select uses the latched offset, not the live address.
    always_comb begin
        rdata_shift   = mem_rdata_i >> {off_q, 3'b000};
        rdata_aligned = mem_rdata_i;
        unique case (size_q)
            2'b00: rdata_aligned = zext_q ? {24'b0, rdata_shift[7:0]}
                                          : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01: rdata_aligned = zext_q ? {16'b0, rdata_shift[15:0]}
                                          : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            default: rdata_aligned = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        mem_fault_d  = 1'b0;
        size_d       = size_q;
        zext_d       = zext_q;
        off_d        = off_q;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    cnt_d       = '0;
                    mem_we_d    = memwrite_i;
                    mem_addr_d  = {addr_i[31:2], 2'b00};
                    mem_wdata_d = wdata_rep;
                    mem_be_d    = be_dec;
                    size_d      = funct3_i[1:0];
                    zext_d      = funct3_i[2];
                    off_d       = addr_i[1:0];
                    if (misaligned) begin
                        state_d     = StFault;
                        mem_req_d   = 1'b0;
                        mem_fault_d = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d   = StBusy;
                        mem_req_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem_ready_i) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        load_data_d  = rdata_aligned;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d     = StFault;
                    mem_req_d   = 1'b0;
                    mem_fault_d = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            mem_fault_q  <= 1'b0;
            size_q       <= '0;
            zext_q       <= 1'b0;
            off_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            mem_fault_q  <= mem_fault_d;
            size_q       <= size_d;
            zext_q       <= zext_d;
            off_q        <= off_d;
        end
    end

    assign stall_o = rst_ni & (((state_q == StIdle) & access) | (state_q == StBusy));

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign mem_fault_o  = mem_fault_q;

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq: loads, stores, misalignment, timeout, mid-access reset.
module tb_dmem_access_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        memread_i, memwrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o, mem_fault_o;

    int n_checks = 0;
    int n_errors = 0;

    dmem_access_seq #(.TIMEOUT(15)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .mem_fault_o  (mem_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic decode(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        memread_i  = rd;
        memwrite_i = wr;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
    endtask

    task automatic idle_inputs();
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        funct3_i   = 3'b000;
        addr_i     = '0;
        wdata_i    = '0;
    endtask

    // One-wait-state load: decode, BUSY with ready, then DONE checks.
    task automatic load_once(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rd, input logic [3:0] be_exp,
                             input logic [31:0] data_exp);
        decode(1'b1, 1'b0, f3, a, 32'h0);
        #1;
        check({tag, "_stall0"}, 32'(stall_o), 32'd1);
        tick();
        idle_inputs();
        check({tag, "_req"}, 32'(mem_req_o), 32'd1);
        check({tag, "_we"}, 32'(mem_we_o), 32'd0);
        check({tag, "_be"}, 32'(mem_be_o), 32'(be_exp));
        check({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
        check({tag, "_stall1"}, 32'(stall_o), 32'd1);
        mem_ready_i = 1'b1;
        mem_rdata_i = rd;
        tick();
        mem_ready_i = 1'b0;
        check({tag, "_valid"}, 32'(load_valid_o), 32'd1);
        check({tag, "_data"}, load_data_o, data_exp);
        check({tag, "_stall2"}, 32'(stall_o), 32'd0);
        check({tag, "_req_done"}, 32'(mem_req_o), 32'd0);
        tick();
        check({tag, "_valid_after"}, 32'(load_valid_o), 32'd0);
    endtask

    initial begin
        int busy;
        rst_ni      = 1'b0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        idle_inputs();
        memread_i = 1'b1;
        repeat (3) tick();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_valid", 32'(load_valid_o), 32'd0);
        check("rst_fault", 32'(mem_fault_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        memread_i = 1'b0;
        rst_ni = 1'b1;
        tick();

        load_once("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        load_once("lb", 3'b000, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
        load_once("lbu", 3'b100, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'h0000_0080);
        load_once("lh", 3'b001, 32'h0000_0202, 32'h9ABC_1234, 4'b1100, 32'hFFFF_9ABC);
        load_once("lhu", 3'b101, 32'h0000_0200, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);

        // Store half
        decode(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD);
        #1;
        check("sh_stall0", 32'(stall_o), 32'd1);
        tick();
        idle_inputs();
        check("sh_req", 32'(mem_req_o), 32'd1);
        check("sh_we", 32'(mem_we_o), 32'd1);
        check("sh_be", 32'(mem_be_o), 32'hC);
        check("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        check("sh_addr", mem_addr_o, 32'h0000_0100);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("sh_valid", 32'(load_valid_o), 32'd0);
        check("sh_stall2", 32'(stall_o), 32'd0);
        tick();

        // Both decoded: store wins, byte replicated
        decode(1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_005A);
        tick();
        idle_inputs();
        check("prio_we", 32'(mem_we_o), 32'd1);
        check("prio_be", 32'(mem_be_o), 32'h2);
        check("prio_wdata", mem_wdata_o, 32'h5A5A_5A5A);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("prio_valid", 32'(load_valid_o), 32'd0);
        tick();

        // Misaligned word load
        decode(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        #1;
        check("mis_stall0", 32'(stall_o), 32'd1);
        tick();
        idle_inputs();
        check("mis_req", 32'(mem_req_o), 32'd0);
        check("mis_fault", 32'(mem_fault_o), 32'd1);
        check("mis_stall1", 32'(stall_o), 32'd0);
        check("mis_data", load_data_o, 32'h0);
        check("mis_valid", 32'(load_valid_o), 32'd0);
        tick();
        check("mis_fault_off", 32'(mem_fault_o), 32'd0);

        // Illegal size 11 also faults
        decode(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        tick();
        idle_inputs();
        check("ill_req", 32'(mem_req_o), 32'd0);
        check("ill_fault", 32'(mem_fault_o), 32'd1);
        tick();

        // Timeout: count BUSY cycles until fault
        decode(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        idle_inputs();
        busy = 0;
        while (mem_req_o && busy < 40) begin
            busy++;
            tick();
        end
        check("to_busy_cycles", 32'(busy), 32'd15);
        check("to_fault", 32'(mem_fault_o), 32'd1);
        check("to_stall", 32'(stall_o), 32'd0);
        tick();
        check("to_fault_off", 32'(mem_fault_o), 32'd0);

        // Ready in BUSY cycle 15 beats the timeout
        decode(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        idle_inputs();
        repeat (14) tick();
        check("late_req", 32'(mem_req_o), 32'd1);
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0BAD_CAFE;
        tick();
        mem_ready_i = 1'b0;
        check("late_valid", 32'(load_valid_o), 32'd1);
        check("late_fault", 32'(mem_fault_o), 32'd0);
        check("late_data", load_data_o, 32'h0BAD_CAFE);
        tick();
        check("late_fault_after", 32'(mem_fault_o), 32'd0);

        // Reset in BUSY cycle 3, then a stray ready
        decode(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        idle_inputs();
        repeat (2) tick();
        check("mr_req_before", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        check("mr_req", 32'(mem_req_o), 32'd0);
        check("mr_addr", mem_addr_o, 32'h0);
        check("mr_data", load_data_o, 32'h0);
        check("mr_stall", 32'(stall_o), 32'd0);
        rst_ni = 1'b1;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        tick();
        mem_ready_i = 1'b0;
        check("mr_stray_valid", 32'(load_valid_o), 32'd0);
        check("mr_stray_req", 32'(mem_req_o), 32'd0);
        tick();
        check("mr_stray_valid2", 32'(load_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
